pipe_stream_sink: RTL
=====================

# pipe_stream_sink

Consumer end of the team's valid/ready pipe protocol. It accepts a stream of beats from any pipe stage, such as the skid buffer or forward slice, and drives `i_ready` with a configurable backpressure pattern: always-ready, LFSR-random, or fixed on/off duty. It checks that the data is an incrementing sequence and that the upstream side obeys the hold rules. It reports errors, the first mismatch, and a pass/done result. It is synthesizable and is used both in benches and in on-chip loopback self-test.

## Interface
Parameters:
- `DWIDTH`, 8, beat data width.
- `LFSR_SEED`, 16'hACE1, LFSR value on reset and on every `start`; must be non-zero.

Ports (reset is synchronous and active-high):
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `i_data`  in  DWIDTH  beat data from upstream.
- `i_valid`  in  1  upstream beat valid.
- `i_ready`  out  1  sink ready; registered output.
- `start`  in  1  single-cycle pulse; latches cfg and begins a run.
- `cfg_mode`  in  2  backpressure mode: 0 = always ready, 1 = LFSR, 2 = duty, 3 = treated as 0.
- `cfg_len`  in  16  number of beats to accept.
- `cfg_first`  in  DWIDTH  expected value of beat 0.
- `cfg_on`  in  4  duty mode: ready-high cycles (0 treated as 1).
- `cfg_off`  in  4  duty mode: ready-low cycles.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `pass`  out  1  `done` and `err_cnt == 0` and `!proto_err`.
- `beat_cnt`  out  16  beats accepted in the current run.
- `err_cnt`  out  16  data mismatches; saturates at 16'hFFFF.
- `proto_err`  out  1  sticky hold-rule violation.
- `first_err_got`  out  DWIDTH  data of the first mismatch.
- `first_err_exp`  out  DWIDTH  expected value at the first mismatch.

## Operation
- FSM states: IDLE, RUN, DONE. All outputs are 0 at reset; state is IDLE; LFSR = `LFSR_SEED`.
- IDLE or DONE with `start`:
  - Latch all cfg inputs.
  - Clear `beat_cnt`, `err_cnt`, `proto_err`, `first_err_*`.
  - Set expected value to `cfg_first` and reload the LFSR with the seed.
  - Go to RUN, or go directly to DONE if `cfg_len == 0`.
- `start` in RUN is ignored.
- Handshake: the beat is accepted at a rising edge where `i_valid && i_ready`.
- On each accepted beat:
  - `beat_cnt` increments.
  - The expected value increments mod 2^DWIDTH, whether or not the beat matched.
  - On a mismatch, `err_cnt` increments (saturating), and `first_err_*` are captured only when `err_cnt` was 0.
- RUN → DONE at the edge that accepts beat number `cfg_len`.
- DONE holds until `start` or `rst`.
- Backpressure generator runs only in RUN; `i_ready` is 0 in IDLE and DONE:
  - Mode 0: `i_ready` = 1.
  - Mode 1: 16-bit Galois LFSR, mask 16'hB400, shifted right every RUN cycle; `i_ready` = next-state bit 0.
  - Mode 2: `i_ready` high for `cfg_on` cycles, then low for `cfg_off` cycles, repeating. The pattern starts with the on-phase. If `cfg_off == 0`, `i_ready` stays high.
- Protocol check, in RUN only: if at an edge `i_valid && !i_ready`, then at the next edge `i_valid` must be 1 and `i_data` must be unchanged. Otherwise `proto_err` is set and stays set until `start` or `rst`.
- `rst` mid-run: at that edge, everything returns to its reset value and any in-flight beat is dropped.

## Timing
- `i_ready` is a flop output and has no combinational path from `i_valid`.
- `start` sampled at edge k: `busy` and `i_ready` (mode 0) become 1 after edge k. The first beat can be accepted at edge k+1.
- Final beat accepted at edge m: after edge m, `i_ready` = 0, `busy` = 0, `done` = 1. `pass` is valid in the same cycle as `done`.
- Counter and error outputs update in the cycle after the accepting edge.
- Mode 0 with upstream always valid: sustains 1 beat/cycle. A run of `cfg_len` beats takes `cfg_len` + 1 cycles from `start` to `done`.

## Test plan
- Mode 0, `cfg_first` = 0x01, `cfg_len` = 55, upstream sends 1..55 back-to-back → `done` 56 cycles after `start`, `beat_cnt` = 55, `pass` = 1.
- Mode 1, same stream, upstream obeys hold rules → `pass` = 1, and the `i_ready` sequence matches a reference LFSR model seeded with 16'hACE1.
- Mode 2, `cfg_on` = 2, `cfg_off` = 3, `cfg_len` = 10 → `i_ready` pattern 1,1,0,0,0 repeating, `done` after 10 beats, `pass` = 1.
- Beat 5 sent as 0x40 instead of 0x06, and beat 8 also wrong → `err_cnt` = 2, `first_err_got` = 0x40, `first_err_exp` = 0x06, `pass` = 0. The following beats 0x07… are not counted as errors.
- Upstream drops `i_valid` while `i_ready` = 0 (mode 2) → `proto_err` = 1 and `pass` = 0 at `done`. A new `start` clears `proto_err`.
- `rst` asserted at beat 20 of 55 → all outputs 0 the next cycle. `cfg_len` = 0 with `start` → `done` = 1 and `pass` = 1 the next cycle, with no beats accepted. `cfg_first` = 0xFE, `cfg_len` = 4 → data 0xFE, 0xFF, 0x00, 0x01 accepted with no errors.

Source files
------------

// File: rtl/pipe_stream_sink.sv
// pipe_stream_sink: consumer end of a valid/ready pipe. Generates backpressure
// (always-ready, LFSR-random or on/off duty), checks the data is an incrementing
// sequence, monitors upstream hold rules and reports a pass/done result.
module pipe_stream_sink #(
  parameter int unsigned DWIDTH    = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] i_data,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic              start,
  input  logic [1:0]        cfg_mode,
  input  logic [15:0]       cfg_len,
  input  logic [DWIDTH-1:0] cfg_first,
  input  logic [3:0]        cfg_on,
  input  logic [3:0]        cfg_off,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       beat_cnt,
  output logic [15:0]       err_cnt,
  output logic              proto_err,
  output logic [DWIDTH-1:0] first_err_got,
  output logic [DWIDTH-1:0] first_err_exp
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [15:0] LfsrMask = 16'hB400;

  state_e            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [15:0]       len_q, len_d;
  logic [3:0]        on_q, on_d;
  logic [3:0]        off_q, off_d;
  logic [DWIDTH-1:0] exp_q, exp_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [3:0]        phase_cnt_q, phase_cnt_d;
  logic              ready_q, ready_d;
  logic [15:0]       beat_cnt_q, beat_cnt_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic              proto_err_q, proto_err_d;
  logic [DWIDTH-1:0] got_q, got_d;
  logic [DWIDTH-1:0] fexp_q, fexp_d;
  logic              stall_q, stall_d;
  logic [DWIDTH-1:0] held_q, held_d;

  logic              accept;
  logic [15:0]       lfsr_next;
  logic [3:0]        on_eff;

  // i_ready is a flop, so the handshake never depends combinationally on i_valid.
  assign accept    = (state_q == StRun) && i_valid && ready_q;
  assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrMask : 16'h0000);
  assign on_eff    = (on_q == 4'd0) ? 4'd1 : on_q;

  // Next-state: run control, backpressure generator, data checker, hold-rule monitor.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    len_d       = len_q;
    on_d        = on_q;
    off_d       = off_q;
    exp_d       = exp_q;
    lfsr_d      = lfsr_q;
    phase_cnt_d = phase_cnt_q;
    ready_d     = 1'b0;
    beat_cnt_d  = beat_cnt_q;
    err_cnt_d   = err_cnt_q;
    proto_err_d = proto_err_q;
    got_d       = got_q;
    fexp_d      = fexp_q;
    stall_d     = 1'b0;
    held_d      = held_q;

    case (state_q)
      StRun: begin
        // A beat stalled at the previous edge must still be offered, unchanged.
        if (stall_q && (!i_valid || (i_data != held_q))) begin
          proto_err_d = 1'b1;
        end
        stall_d = i_valid && !ready_q;
        held_d  = i_data;

        // ready_q doubles as the duty phase flag; phase_cnt_q counts cycles spent in it.
        lfsr_d = lfsr_next;
        case (mode_q)
          2'd1: ready_d = lfsr_next[0];
          2'd2: begin
            if (off_q == 4'd0) begin
              ready_d = 1'b1;
            end else if (ready_q) begin
              if (phase_cnt_q >= on_eff) begin
                ready_d     = 1'b0;
                phase_cnt_d = 4'd1;
              end else begin
                ready_d     = 1'b1;
                phase_cnt_d = phase_cnt_q + 4'd1;
              end
            end else begin
              if (phase_cnt_q >= off_q) begin
                ready_d     = 1'b1;
                phase_cnt_d = 4'd1;
              end else begin
                ready_d     = 1'b0;
                phase_cnt_d = phase_cnt_q + 4'd1;
              end
            end
          end
          default: ready_d = 1'b1;
        endcase

        if (accept) begin
          beat_cnt_d = beat_cnt_q + 16'd1;
          // Expected value advances regardless of match, so one bad beat costs one error.
          exp_d = exp_q + 1'b1;
          if (i_data != exp_q) begin
            if (err_cnt_q == 16'd0) begin
              got_d  = i_data;
              fexp_d = exp_q;
            end
            if (err_cnt_q != 16'hFFFF) begin
              err_cnt_d = err_cnt_q + 16'd1;
            end
          end
          if (beat_cnt_d == len_q) begin
            state_d = StDone;
            ready_d = 1'b0;
          end
        end
      end
      default: begin
        if (start) begin
          mode_d      = cfg_mode;
          len_d       = cfg_len;
          on_d        = cfg_on;
          off_d       = cfg_off;
          exp_d       = cfg_first;
          lfsr_d      = LFSR_SEED;
          phase_cnt_d = 4'd1;
          beat_cnt_d  = 16'd0;
          err_cnt_d   = 16'd0;
          proto_err_d = 1'b0;
          got_d       = '0;
          fexp_d      = '0;
          if (cfg_len == 16'd0) begin
            state_d = StDone;
          end else begin
            state_d = StRun;
            // In LFSR mode i_ready always mirrors bit 0 of the LFSR register.
            ready_d = (cfg_mode == 2'd1) ? LFSR_SEED[0] : 1'b1;
          end
        end
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      mode_q      <= 2'd0;
      len_q       <= 16'd0;
      on_q        <= 4'd0;
      off_q       <= 4'd0;
      exp_q       <= '0;
      lfsr_q      <= LFSR_SEED;
      phase_cnt_q <= 4'd0;
      ready_q     <= 1'b0;
      beat_cnt_q  <= 16'd0;
      err_cnt_q   <= 16'd0;
      proto_err_q <= 1'b0;
      got_q       <= '0;
      fexp_q      <= '0;
      stall_q     <= 1'b0;
      held_q      <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      len_q       <= len_d;
      on_q        <= on_d;
      off_q       <= off_d;
      exp_q       <= exp_d;
      lfsr_q      <= lfsr_d;
      phase_cnt_q <= phase_cnt_d;
      ready_q     <= ready_d;
      beat_cnt_q  <= beat_cnt_d;
      err_cnt_q   <= err_cnt_d;
      proto_err_q <= proto_err_d;
      got_q       <= got_d;
      fexp_q      <= fexp_d;
      stall_q     <= stall_d;
      held_q      <= held_d;
    end
  end

  assign i_ready       = ready_q;
  assign busy          = (state_q == StRun);
  assign done          = (state_q == StDone);
  assign pass          = done && (err_cnt_q == 16'd0) && !proto_err_q;
  assign beat_cnt      = beat_cnt_q;
  assign err_cnt       = err_cnt_q;
  assign proto_err     = proto_err_q;
  assign first_err_got = got_q;
  assign first_err_exp = fexp_q;

endmodule
